// File: rtl/switch_gate_debounced.sv
// ============================================================================
// Module      : switch_gate_debounced
// Description : Synchronises and debounces NUM_SWITCHES raw switches, reduces
//               the debounced vector (AND/OR/XOR/NAND) onto a registered LED.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_gate_debounced #(
    parameter int NUM_SWITCHES   = 2,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    input  logic [1:0]              i_Mode,
    output logic [NUM_SWITCHES-1:0] o_Stable,
    output logic                    o_LED_1,
    output logic                    o_Change
);

    localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0] c_LIMIT_M1 = CW'(DEBOUNCE_LIMIT - 1);

    localparam logic [1:0] c_MODE_AND  = 2'b00;
    localparam logic [1:0] c_MODE_OR   = 2'b01;
    localparam logic [1:0] c_MODE_XOR  = 2'b10;
    localparam logic [1:0] c_MODE_NAND = 2'b11;

    logic [NUM_SWITCHES-1:0] r_sync1;
    logic [NUM_SWITCHES-1:0] r_sync2;
    logic [NUM_SWITCHES-1:0] r_stable;
    logic [NUM_SWITCHES-1:0] w_accept;
    logic                    r_led;
    logic                    r_change;
    logic                    w_f;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_Switch;
            r_sync2 <= r_sync1;
        end
    end

    // Each channel owns its counter; an accept only ever flips the stable bit
    // because it is raised solely while the synchronised input disagrees.
    for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_chan
        logic [CW-1:0] r_count;
        logic          w_mismatch;

        assign w_mismatch  = r_sync2[i] ^ r_stable[i];
        assign w_accept[i] = w_mismatch && (r_count == c_LIMIT_M1);

        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                r_count <= '0;
            end else if (!w_mismatch || w_accept[i]) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_f = 1'b0;
        case (i_Mode)
            c_MODE_AND:  w_f = &r_stable;
            c_MODE_OR:   w_f = |r_stable;
            c_MODE_XOR:  w_f = ^r_stable;
            c_MODE_NAND: w_f = ~&r_stable;
            default:     w_f = 1'b0;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_stable <= '0;
            r_led    <= 1'b0;
            r_change <= 1'b0;
        end else begin
            r_stable <= r_stable ^ w_accept;
            r_led    <= w_f;
            r_change <= (w_f != r_led);
        end
    end

    assign o_Stable = r_stable;
    assign o_LED_1  = r_led;
    assign o_Change = r_change;

endmodule

`default_nettype wire

// File: tb/tb_switch_gate_debounced.sv
// ============================================================================
// Module      : tb_switch_gate_debounced
// Description : Directed self-checking bench for switch_gate_debounced.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_gate_debounced;

    logic       clk;
    logic       rst_n;
    logic [1:0] sw;
    logic [1:0] mode;
    logic [1:0] stable;
    logic       led;
    logic       change;

    int n_checks;
    int n_fail;
    int chg_cnt;
    int chg_base;

    switch_gate_debounced #(
        .NUM_SWITCHES   (2),
        .DEBOUNCE_LIMIT (4)
    ) u_dut (
        .i_Clk    (clk),
        .i_Rst_L  (rst_n),
        .i_Switch (sw),
        .i_Mode   (mode),
        .o_Stable (stable),
        .o_LED_1  (led),
        .o_Change (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts change pulses, sampled mid-cycle.
    always @(negedge clk) if (change === 1'b1) chg_cnt++;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chg_cnt  = 0;
        rst_n    = 1'b0;
        sw       = 2'b00;
        mode     = 2'b00;
        #1;
        check_value("rst_stable", 32'(stable), 32'h0);
        check_value("rst_led",    32'(led),    32'h0);
        check_value("rst_change", 32'(change), 32'h0);
        edges(2);
        rst_n = 1'b1;
        edges(5);

        // 1: AND walk
        chg_base = chg_cnt;
        sw = 2'b01; edges(20);
        check_value("t1_stable01", 32'(stable), 32'h1);
        check_value("t1_led01",    32'(led),    32'h0);
        sw = 2'b10; edges(20);
        check_value("t1_stable10", 32'(stable), 32'h2);
        check_value("t1_led10",    32'(led),    32'h0);
        sw = 2'b11; edges(5);
        check_value("t1_stable_e5", 32'(stable), 32'h2);
        edges(1);
        check_value("t1_stable_e6", 32'(stable), 32'h3);
        check_value("t1_led_e6",    32'(led),    32'h0);
        edges(1);
        check_value("t1_led_e7",    32'(led),    32'h1);
        check_value("t1_change_e7", 32'(change), 32'h1);
        edges(1);
        check_value("t1_change_e8", 32'(change), 32'h0);
        edges(12);
        check_value("t1_pulses", 32'(chg_cnt - chg_base), 32'd1);

        // 2: glitch rejection
        sw = 2'b00; edges(20);
        check_value("t2_setup", 32'(stable), 32'h0);
        chg_base = chg_cnt;
        sw = 2'b01; edges(3);
        sw = 2'b00; edges(2);
        check_value("t2_mid",   32'(stable), 32'h0);
        edges(18);
        check_value("t2_stable", 32'(stable), 32'h0);
        check_value("t2_pulses", 32'(chg_cnt - chg_base), 32'd0);

        // 3: mode stepping with switches = 11
        sw = 2'b11; edges(20);
        check_value("t3_and", 32'(led), 32'h1);
        mode = 2'b01; edges(1);
        check_value("t3_or",  32'(led), 32'h1);
        check_value("t3_or_chg", 32'(change), 32'h0);
        mode = 2'b10; edges(1);
        check_value("t3_xor", 32'(led), 32'h0);
        check_value("t3_xor_chg", 32'(change), 32'h1);
        mode = 2'b11; edges(1);
        check_value("t3_nand", 32'(led), 32'h0);
        check_value("t3_nand_chg", 32'(change), 32'h0);

        // 4: simultaneous accept in XOR mode
        mode = 2'b10; sw = 2'b00; edges(20);
        check_value("t4_setup", 32'(stable), 32'h0);
        chg_base = chg_cnt;
        sw = 2'b11; edges(5);
        check_value("t4_e5", 32'(stable), 32'h0);
        edges(1);
        check_value("t4_e6", 32'(stable), 32'h3);
        edges(10);
        check_value("t4_led",    32'(led), 32'h0);
        check_value("t4_pulses", 32'(chg_cnt - chg_base), 32'd0);

        // 5: reset mid-count in OR mode
        mode = 2'b01; sw = 2'b01; edges(20);
        check_value("t5_stable_pre", 32'(stable), 32'h1);
        check_value("t5_led_pre",    32'(led),    32'h1);
        sw = 2'b11;
        for (int k = 0; k < 4; k++) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_value("t5_async_stable", 32'(stable), 32'h0);
        check_value("t5_async_led",    32'(led),    32'h0);
        check_value("t5_async_change", 32'(change), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        edges(5);
        check_value("t5_e5", 32'(stable), 32'h0);
        edges(1);
        check_value("t5_e6", 32'(stable), 32'h3);
        edges(1);
        check_value("t5_led_e7", 32'(led), 32'h1);

        // 6: release in NAND mode with switches = 00
        @(negedge clk);
        rst_n = 1'b0;
        sw    = 2'b00;
        mode  = 2'b11;
        edges(2);
        check_value("t6_rst_led", 32'(led), 32'h0);
        chg_base = chg_cnt;
        rst_n = 1'b1;
        edges(1);
        check_value("t6_led_e1",    32'(led),    32'h1);
        check_value("t6_change_e1", 32'(change), 32'h1);
        edges(1);
        check_value("t6_change_e2", 32'(change), 32'h0);
        edges(10);
        check_value("t6_pulses", 32'(chg_cnt - chg_base), 32'd1);
        check_value("t6_stable", 32'(stable), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
